dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, data word width of both requesters and of the memory port.
REQ-002 Parameter ADDR_W, default 9, word-address width of both requesters and of the memory port.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 p0_req / p1_req  input  1  access request, port 0 (core load/store) / port 1 (auxiliary loader).
REQ-006 p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-007 p0_addr / p1_addr  input  ADDR_W  word address.
REQ-008 p0_wdata / p1_wdata  input  DATA_W  write data.
REQ-009 p0_gnt / p1_gnt  output  1  one-cycle pulse; request accepted and issued to memory.
REQ-010 p0_rvalid / p1_rvalid  output  1  one-cycle pulse; read data valid on pN_rdata.
REQ-011 p0_rdata / p1_rdata  output  DATA_W  registered read data, held until next read completes on that port.
REQ-012 mem_wr / mem_rd  output  1  memory write / read strobe, one cycle.
REQ-013 mem_addr  output  ADDR_W  memory address.
REQ-014 mem_wr_data  output  DATA_W  memory write data.
REQ-015 mem_rd_data  input  DATA_W  memory read data, valid the cycle after mem_rd.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states IDLE, ISSUE, RESP; all outputs registered.
REQ-018 IDLE, no request: remain IDLE; mem_wr, mem_rd, all gnt/rvalid low.
REQ-019 IDLE, one or more requests: select winner, latch its we/addr/wdata and port id, go to ISSUE next cycle.
REQ-020 Single requester wins unconditionally.
REQ-021 Both requesting: round-robin; winner is the port that did not win the previous arbitration; last-winner register reset value = 1, so port 0 wins the first tie.
REQ-022 Last-winner register updates only on an arbitration with at least one request.
REQ-023 ISSUE: drive latched mem_addr and mem_wr_data; mem_wr = latched we, mem_rd = !latched we; pulse winner's pN_gnt; non-winner gnt low.
REQ-024 ISSUE, write: next state IDLE; write latency request-to-strobe = 1 cycle, occupancy 2 cycles.
REQ-025 ISSUE, read: next state RESP.
REQ-026 RESP: capture mem_rd_data into winner's pN_rdata, pulse winner's pN_rvalid, next state IDLE; read latency request-sample to rvalid = 2 cycles, occupancy 3 cycles.
REQ-027 Requester holds req/we/addr/wdata stable until gnt and deasserts req in the cycle after gnt; req still high in the IDLE after completion is a new request.
REQ-028 Requests arriving in ISSUE/RESP are ignored until IDLE; no queuing beyond one in-flight access.
REQ-029 Request dropped before gnt: if already latched it completes normally (gnt, and rvalid for reads).
REQ-030 mem_wr and mem_rd never high simultaneously; at most one gnt and at most one rvalid high per cycle.
REQ-031 mem_addr/mem_wr_data hold last issued value outside ISSUE; memory qualifies them only by strobes.

Reset
REQ-032 reset forces IDLE immediately, regardless of clk.
REQ-033 Reset values: all gnt, rvalid, mem_wr, mem_rd, busy = 0; mem_addr, mem_wr_data, p0_rdata, p1_rdata = 0; last-winner = 1.
REQ-034 Reset mid-access: in-flight access abandoned; no gnt/rvalid issued for it after reset release.
REQ-035 First arbitration is in the first rising edge with reset low.

Verification
REQ-036 p0 write addr 0x005 data 0xDEADBEEF alone -> next cycle mem_wr=1, mem_addr=0x005, mem_wr_data=0xDEADBEEF, p0_gnt=1; busy 1 cycle.
REQ-037 p1 read addr 0x1FF, memory returns 0x12345678 -> mem_rd=1 cycle N+1, p1_rvalid=1 with p1_rdata=0x12345678 cycle N+2; p0_rdata unchanged.
REQ-038 p0 and p1 both hold read requests continuously after reset -> grants alternate p0, p1, p0, p1, one gnt per 3 cycles.
REQ-039 p1 request raised during p0 ISSUE -> ignored until IDLE, then p1 granted; mem_wr and mem_rd never overlap.
REQ-040 Reset asserted in RESP of a p0 read -> outputs zero immediately, no p0_rvalid after release, next tie grants p0.
REQ-041 Back-to-back p0 writes to 0x000 and 0x1FF (wrap boundary) -> two mem_wr pulses 2 cycles apart, addresses exact, no truncation.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: the core load/store port (p0) and an auxiliary
// loader port (p1) share one single-cycle memory. Ties alternate round-robin;
// at most one access is in flight. All outputs come straight from registers.
module dmem_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,

    output logic              busy
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

    state_e              state_q;
    logic                last_q;    // 1: port 1 won the most recent arbitration
    logic                id_q;      // port owning the in-flight access
    logic                we_q;      // in-flight access is a write
    logic                p0_gnt_q, p1_gnt_q;
    logic                p0_rvalid_q, p1_rvalid_q;
    logic [DATA_W-1:0]   p0_rdata_q, p1_rdata_q;
    logic                mem_wr_q, mem_rd_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wr_data_q;
    logic                busy_q;

    logic                sel_p1;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // Pick the winner among current requests; a tie goes to the port that lost last time.
    always_comb begin
        if (p0_req && p1_req) begin
            sel_p1 = ~last_q;
        end else begin
            sel_p1 = p1_req;
        end
        sel_we    = sel_p1 ? p1_we    : p0_we;
        sel_addr  = sel_p1 ? p1_addr  : p0_addr;
        sel_wdata = sel_p1 ? p1_wdata : p0_wdata;
    end

    // Arbitration FSM; every output is a register written here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            last_q        <= 1'b1;
            id_q          <= 1'b0;
            we_q          <= 1'b0;
            p0_gnt_q      <= 1'b0;
            p1_gnt_q      <= 1'b0;
            p0_rvalid_q   <= 1'b0;
            p1_rvalid_q   <= 1'b0;
            p0_rdata_q    <= '0;
            p1_rdata_q    <= '0;
            mem_wr_q      <= 1'b0;
            mem_rd_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            // Pulsed outputs default low; address/data registers hold.
            p0_gnt_q    <= 1'b0;
            p1_gnt_q    <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (p0_req || p1_req) begin
                        state_q       <= StIssue;
                        busy_q        <= 1'b1;
                        last_q        <= sel_p1;
                        id_q          <= sel_p1;
                        we_q          <= sel_we;
                        // Strobes and grant are registered here so they are
                        // visible for exactly the ISSUE cycle.
                        mem_wr_q      <= sel_we;
                        mem_rd_q      <= ~sel_we;
                        mem_addr_q    <= sel_addr;
                        mem_wr_data_q <= sel_wdata;
                        p0_gnt_q      <= ~sel_p1;
                        p1_gnt_q      <= sel_p1;
                    end
                end
                StIssue: begin
                    if (we_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    // Memory read data is valid during this cycle.
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    if (id_q) begin
                        p1_rdata_q  <= mem_rd_data;
                        p1_rvalid_q <= 1'b1;
                    end else begin
                        p0_rdata_q  <= mem_rd_data;
                        p0_rvalid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign p0_gnt      = p0_gnt_q;
    assign p1_gnt      = p1_gnt_q;
    assign p0_rvalid   = p0_rvalid_q;
    assign p1_rvalid   = p1_rvalid_q;
    assign p0_rdata    = p0_rdata_q;
    assign p1_rdata    = p1_rdata_q;
    assign mem_wr      = mem_wr_q;
    assign mem_rd      = mem_rd_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign busy        = busy_q;

    // Exclusivity of strobes, grants and read responses.
    a_strobe_excl: assert property (@(posedge clk) disable iff (reset) !(mem_wr && mem_rd));
    a_gnt_excl:    assert property (@(posedge clk) disable iff (reset) !(p0_gnt && p1_gnt));
    a_rvalid_excl: assert property (@(posedge clk) disable iff (reset) !(p0_rvalid && p1_rvalid));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one task per scenario, inline checks.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [8:0]  p0_addr = '0;
    logic [31:0] p0_wdata = '0;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [8:0]  p1_addr = '0;
    logic [31:0] p1_wdata = '0;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_wr, mem_rd, busy;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data = '0;

    int tests = 0;
    int fails = 0;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(9)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory stand-in: 0x1FF holds 0x12345678, others read {A5A5, addr}; data valid next cycle.
    always @(posedge clk) begin
        if (mem_rd) begin
            if (mem_addr == 9'h1FF) mem_rd_data <= 32'h1234_5678;
            else                    mem_rd_data <= {16'hA5A5, 7'h00, mem_addr};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        tests++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_wr, mem_rd, busy} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: gnt=%b%b rvalid=%b%b wr=%b rd=%b busy=%b, expected all 0",
                     p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_wr, mem_rd, busy);
        end
        tests++;
        if (mem_addr !== 9'h000 || mem_wr_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_mem: addr=%h wdata=%h, expected 000/00000000", mem_addr, mem_wr_data);
        end
        tests++;
        if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_rdata: p0=%h p1=%h, expected 0/0", p0_rdata, p1_rdata);
        end
        reset = 1'b0;
        step();
        tests++;
        if ({p0_gnt, p1_gnt, mem_wr, mem_rd, busy} !== 5'b0) begin
            fails++;
            $display("FAIL idle_noreq: gnt=%b%b wr=%b rd=%b busy=%b, expected all 0",
                     p0_gnt, p1_gnt, mem_wr, mem_rd, busy);
        end
    endtask

    task automatic test_p0_write();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h005; p0_wdata = 32'hDEAD_BEEF;
        step();
        tests++;
        if ({mem_wr, mem_rd, p0_gnt, p1_gnt, busy} !== 5'b10101) begin
            fails++;
            $display("FAIL wr_issue: wr,rd,g0,g1,busy=%b, expected 10101",
                     {mem_wr, mem_rd, p0_gnt, p1_gnt, busy});
        end
        tests++;
        if (mem_addr !== 9'h005 || mem_wr_data !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL wr_bus: addr=%h data=%h, expected 005/deadbeef", mem_addr, mem_wr_data);
        end
        p0_req = 1'b0;
        step();
        tests++;
        if ({mem_wr, p0_gnt, busy} !== 3'b000 || mem_addr !== 9'h005) begin
            fails++;
            $display("FAIL wr_done: wr,g0,busy=%b addr=%h, expected 000 addr 005",
                     {mem_wr, p0_gnt, busy}, mem_addr);
        end
    endtask

    task automatic test_p1_read();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h1FF;
        step();
        tests++;
        if ({mem_rd, mem_wr, p1_gnt, p0_gnt, busy} !== 5'b10101 || mem_addr !== 9'h1FF) begin
            fails++;
            $display("FAIL rd_issue: rd,wr,g1,g0,busy=%b addr=%h, expected 10101 addr 1ff",
                     {mem_rd, mem_wr, p1_gnt, p0_gnt, busy}, mem_addr);
        end
        p1_req = 1'b0;
        step();
        tests++;
        if ({mem_rd, p1_gnt, p1_rvalid, busy} !== 4'b0001) begin
            fails++;
            $display("FAIL rd_resp: rd,g1,rv1,busy=%b, expected 0001",
                     {mem_rd, p1_gnt, p1_rvalid, busy});
        end
        step();
        tests++;
        if ({p1_rvalid, p0_rvalid, busy} !== 3'b100 || p1_rdata !== 32'h1234_5678) begin
            fails++;
            $display("FAIL rd_data: rv1,rv0,busy=%b rdata=%h, expected 100 12345678",
                     {p1_rvalid, p0_rvalid, busy}, p1_rdata);
        end
        tests++;
        if (p0_rdata !== 32'h0) begin
            fails++;
            $display("FAIL rd_p0_untouched: p0_rdata=%h, expected 00000000", p0_rdata);
        end
        step();
        tests++;
        if (p1_rvalid !== 1'b0 || p1_rdata !== 32'h1234_5678) begin
            fails++;
            $display("FAIL rd_hold: rv1=%b rdata=%h, expected 0 12345678", p1_rvalid, p1_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic        exp_p1;
        logic [8:0]  exp_addr;
        logic [31:0] exp_data;
        reset = 1'b1;
        step();
        reset = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h010;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h020;
        for (int g = 0; g < 4; g++) begin
            exp_p1   = (g % 2) == 1;
            exp_addr = exp_p1 ? 9'h020 : 9'h010;
            exp_data = exp_p1 ? 32'hA5A5_0020 : 32'hA5A5_0010;
            step();
            tests++;
            if ({p0_gnt, p1_gnt} !== {~exp_p1, exp_p1} || mem_rd !== 1'b1
                || mem_addr !== exp_addr) begin
                fails++;
                $display("FAIL rr_gnt%0d: g0g1=%b rd=%b addr=%h, expected %b 1 %h",
                         g, {p0_gnt, p1_gnt}, mem_rd, mem_addr, {~exp_p1, exp_p1}, exp_addr);
            end
            step();
            tests++;
            if ({p0_gnt, p1_gnt, mem_rd, mem_wr} !== 4'b0000) begin
                fails++;
                $display("FAIL rr_resp%0d: g0,g1,rd,wr=%b, expected 0000",
                         g, {p0_gnt, p1_gnt, mem_rd, mem_wr});
            end
            step();
            tests++;
            if ({p0_rvalid, p1_rvalid} !== {~exp_p1, exp_p1}
                || (exp_p1 ? p1_rdata : p0_rdata) !== exp_data) begin
                fails++;
                $display("FAIL rr_data%0d: rv0rv1=%b rdata=%h, expected %b %h", g,
                         {p0_rvalid, p1_rvalid}, exp_p1 ? p1_rdata : p0_rdata,
                         {~exp_p1, exp_p1}, exp_data);
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        step();
    endtask

    task automatic test_ignore_during_issue();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h033; p0_wdata = 32'h0BAD_F00D;
        step();
        tests++;
        if ({p0_gnt, mem_wr, mem_rd} !== 3'b110) begin
            fails++;
            $display("FAIL ign_p0: g0,wr,rd=%b, expected 110", {p0_gnt, mem_wr, mem_rd});
        end
        p0_req = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h044;
        step();
        tests++;
        if ({p1_gnt, busy, mem_wr, mem_rd} !== 4'b0000) begin
            fails++;
            $display("FAIL ign_idle: g1,busy,wr,rd=%b, expected 0000", {p1_gnt, busy, mem_wr, mem_rd});
        end
        step();
        tests++;
        if ({p1_gnt, p0_gnt, mem_rd, mem_wr} !== 4'b1010 || mem_addr !== 9'h044) begin
            fails++;
            $display("FAIL ign_p1: g1,g0,rd,wr=%b addr=%h, expected 1010 044",
                     {p1_gnt, p0_gnt, mem_rd, mem_wr}, mem_addr);
        end
        p1_req = 1'b0;
        step();
        tests++;
        if (mem_wr === 1'b1 && mem_rd === 1'b1) begin
            fails++;
            $display("FAIL ign_overlap: wr=%b rd=%b, expected not both", mem_wr, mem_rd);
        end
        step();
        tests++;
        if (p1_rvalid !== 1'b1 || p1_rdata !== 32'hA5A5_0044) begin
            fails++;
            $display("FAIL ign_data: rv1=%b rdata=%h, expected 1 a5a50044", p1_rvalid, p1_rdata);
        end
    endtask

    task automatic test_reset_mid_resp();
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h066;
        step();
        tests++;
        if (p0_gnt !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre_gnt: g0=%b, expected 1", p0_gnt);
        end
        p0_req = 1'b0;
        step();
        reset = 1'b1;
        #1;
        tests++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_wr, mem_rd, busy} !== 7'b0
            || mem_addr !== 9'h000 || p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            fails++;
            $display("FAIL rst_async: ctrl=%b addr=%h rd0=%h rd1=%h, expected all 0",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_wr, mem_rd, busy},
                     mem_addr, p0_rdata, p1_rdata);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if ({p0_rvalid, p0_gnt, busy} !== 3'b000) begin
                fails++;
                $display("FAIL rst_abandon%0d: rv0,g0,busy=%b, expected 000",
                         i, {p0_rvalid, p0_gnt, busy});
            end
        end
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h070;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h071;
        step();
        tests++;
        if ({p0_gnt, p1_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL rst_tie: g0g1=%b, expected 10", {p0_gnt, p1_gnt});
        end
        p0_req = 1'b0; p1_req = 1'b0;
        step();
        step();
        tests++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 32'hA5A5_0070) begin
            fails++;
            $display("FAIL rst_tie_data: rv0=%b rdata=%h, expected 1 a5a50070", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_back_to_back();
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h000; p0_wdata = 32'h1111_1111;
        step();
        tests++;
        if ({mem_wr, p0_gnt} !== 2'b11 || mem_addr !== 9'h000 || mem_wr_data !== 32'h1111_1111) begin
            fails++;
            $display("FAIL b2b_first: wr,g0=%b addr=%h data=%h, expected 11 000 11111111",
                     {mem_wr, p0_gnt}, mem_addr, mem_wr_data);
        end
        p0_addr = 9'h1FF; p0_wdata = 32'h2222_2222;
        step();
        tests++;
        if ({mem_wr, busy} !== 2'b00) begin
            fails++;
            $display("FAIL b2b_gap: wr,busy=%b, expected 00", {mem_wr, busy});
        end
        step();
        tests++;
        if ({mem_wr, p0_gnt} !== 2'b11 || mem_addr !== 9'h1FF || mem_wr_data !== 32'h2222_2222) begin
            fails++;
            $display("FAIL b2b_second: wr,g0=%b addr=%h data=%h, expected 11 1ff 22222222",
                     {mem_wr, p0_gnt}, mem_addr, mem_wr_data);
        end
        p0_req = 1'b0;
        step();
        tests++;
        if (mem_wr !== 1'b0 || mem_addr !== 9'h1FF) begin
            fails++;
            $display("FAIL b2b_hold: wr=%b addr=%h, expected 0 1ff", mem_wr, mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_p0_write();
        test_p1_read();
        test_round_robin();
        test_ignore_during_issue();
        test_reset_mid_resp();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
